data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning access wait states; range 0..15.
REQ-003 Clock and reset: clk input, 1 bit, rising-edge clock; rstn input, 1 bit, asynchronous active-low reset.
REQ-004 req_valid  input  1  the initiator presents a request.
REQ-005 req_ready  output  1  the block accepts a request this cycle.
REQ-006 req_we  input  1  1 means store, 0 means load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 resp_valid  output  1  a response is presented.
REQ-012 resp_ready  input  1  the initiator accepts the response.
REQ-013 resp_rdata  output  32  load result, right-aligned and extended.
REQ-014 resp_err  output  1  the request was rejected; no memory side effect.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 on a rising edge.
REQ-017 On handshake, the block SHALL register we, addr, wdata, size and unsigned, then enter WAIT with the wait counter at 0.
REQ-018 In WAIT, the counter increments each cycle; when it equals WAIT_CYCLES the block SHALL perform the access and enter RESP. WAIT_CYCLES=0 means one WAIT cycle.
REQ-019 Latency: a handshake at edge T SHALL make resp_valid=1 after edge T+1+WAIT_CYCLES.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1 on an edge; the block then returns to IDLE. resp_valid=0 in all other states.
REQ-021 Back-to-back requests: req_ready rises in the cycle after the response handshake; there is no overlap.
REQ-022 Error conditions are size=11; half-word with addr[0]=1; word with addr[1:0]!=0; word index addr[31:2] >= DEPTH_WORDS.
REQ-023 On error: no write occurs; resp_err=1; resp_rdata=0.
REQ-024 Store: only the addressed byte lanes SHALL be written (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all four), using the low-order bytes of wdata.
REQ-025 Store response: resp_rdata=0, resp_err=0.
REQ-026 Load: select the byte or half selected by addr[1:0] or addr[1], then zero- or sign-extend it to 32 bits according to req_unsigned; a word load is returned unmodified.
REQ-027 Memory SHALL be a single-port array of DEPTH_WORDS x 32 with a 4-bit byte-write enable; reads are registered into resp_rdata at the access cycle.
REQ-028 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-029 While rstn=0: state IDLE, counter 0, req_ready=1 after reset release, resp_valid=0, resp_rdata=0, resp_err=0, captured request registers 0.
REQ-030 Memory contents SHALL NOT be cleared by reset; contents after power-up are undefined.
REQ-031 If reset asserts during WAIT before the access cycle, the pending store SHALL NOT be written; if it asserts during RESP, the response is dropped and the write already committed remains.

Verification
REQ-032 Word store then load, WAIT_CYCLES=2: store 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 3 cycles after each handshake.
REQ-033 Byte/half lanes: store word 0x00000000 at 0x20, store byte 0x80 at 0x23, then load signed byte at 0x23 -> 0xFFFFFF80; unsigned -> 0x00000080; load word at 0x20 -> 0x80000000; store half 0x1234 at 0x22 -> word reads 0x12340000.
REQ-034 Errors: word load at 0x06 -> resp_err=1, resp_rdata=0; store at word index DEPTH_WORDS -> resp_err=1, and index 0 is unchanged; size=11 -> resp_err=1.
REQ-035 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready=0; resp_ready=1 -> IDLE on the next cycle.
REQ-036 Reset mid-WAIT: store 0x11111111 at 0x40, whose prior content is 0x22222222; assert rstn=0 in the first WAIT cycle, then release and load 0x40 -> 0x22222222; outputs are 0 during reset.
REQ-037 WAIT_CYCLES=0 build: handshake at edge T -> resp_valid=1 after edge T+1.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// One request is outstanding at a time: the request handshake is followed by a single response.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port word memory with byte-lane stores, sign/zero-extending loads and programmable wait states.
// Misaligned, reserved-size or out-of-range requests get an error response and leave memory untouched.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rstn,
  data_mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [1:0]    cap_size;
  logic          cap_unsigned;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          access;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;

  assign access   = (state == S_WAIT) && (wait_cnt == 4'(WAIT_CYCLES));
  assign word_idx = cap_addr[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{cap_addr[1:0], 3'b000} +: 8];
  assign rd_half  = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    req_err = 1'b0;
    case (cap_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = cap_addr[0];
      2'b10:   req_err = (cap_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS)) req_err = 1'b1;
  end

  // Store data is replicated across lanes so the enable mask alone picks the target bytes.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = cap_wdata;
    load_val  = rd_word;
    case (cap_size)
      2'b00: begin
        lane_en   = 4'b0001 << cap_addr[1:0];
        lane_data = {4{cap_wdata[7:0]}};
        load_val  = cap_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        lane_en   = cap_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cap_wdata[15:0]}};
        load_val  = cap_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = cap_wdata;
        load_val  = rd_word;
      end
    endcase
  end

  // No reset on the array: a reset only blocks the write by forcing the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (access && cap_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      cap_we       <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
      cap_size     <= 2'd0;
      cap_unsigned <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            cap_we       <= bus.req_we;
            cap_addr     <= bus.req_addr;
            cap_wdata    <= bus.req_wdata;
            cap_size     <= bus.req_size;
            cap_unsigned <= bus.req_unsigned;
            wait_cnt     <= 4'd0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (access) begin
            err_q   <= req_err;
            rdata_q <= (req_err || cap_we) ? 32'd0 : load_val;
            state   <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
